// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nib_steps(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_addsub_flags.sv
// Result/flag formation from the registered nibble results.
// Optional signed saturation when NIBBLE_SERIAL_ADDSUB_SAT_EN is defined.
module nibble_addsub_flags
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] res,
  input  logic             a_msb,
  input  logic             bp_msb,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             carry
);

  always_comb begin
    overflow = (a_msb == bp_msb) && (res[WIDTH-1] != a_msb);
    result   = res;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
    // Clamp toward the sign of A: overflow only happens when both inputs share it.
    if (overflow) result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    zero  = (result == '0);
    carry = carry_in;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract sequencer driving an external 4-bit ripple adder,
// one nibble per cycle. Saturation is enabled with NIBBLE_SERIAL_ADDSUB_SAT_EN.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_carry,
  output logic                out_overflow,
  output logic                out_zero,
  output logic [NIBBLE_W-1:0] adder_x,
  output logic [NIBBLE_W-1:0] adder_y,
  output logic                adder_cin,
  input  logic [NIBBLE_W-1:0] adder_sum,
  input  logic                adder_cout
);

  localparam int N    = nib_steps(WIDTH);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              sub_q, sub_d, carry_q, carry_d;

  logic [WIDTH-1:0]  f_result;
  logic              f_overflow, f_zero, f_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    in_ready  = 1'b0;
    adder_x   = '0;
    adder_y   = '0;
    adder_cin = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Subtract is A + ~B + 1: the +1 rides in on the first nibble's carry.
        adder_x   = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        adder_y   = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
        adder_cin = (idx_q == '0) ? sub_q : carry_q;
        res_d[idx_q*NIBBLE_W +: NIBBLE_W] = adder_sum;
        carry_d   = adder_cout;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  nibble_addsub_flags #(.WIDTH(WIDTH)) u_flags (
    .res      (res_q),
    .a_msb    (a_q[WIDTH-1]),
    .bp_msb   (b_q[WIDTH-1] ^ sub_q),
    .carry_in (carry_q),
    .result   (f_result),
    .overflow (f_overflow),
    .zero     (f_zero),
    .carry    (f_carry)
  );

  // Result and flags are only presented while a result is being offered.
  always_comb begin
    out_valid    = (state_q == DONE);
    out_result   = out_valid ? f_result : '0;
    out_carry    = out_valid & f_carry;
    out_overflow = out_valid & f_overflow;
    out_zero     = out_valid & f_zero;
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized and directed check of nibble_serial_addsub against an arithmetic model.
module tb_nibble_serial_addsub;

  localparam int W = 16;
  localparam int N = W / 4;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_result;
  logic          out_carry, out_overflow, out_zero;
  logic [3:0]    adder_x, adder_y, adder_sum;
  logic          adder_cin, adder_cout;

  int total = 0;
  int bad   = 0;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .adder_x(adder_x), .adder_y(adder_y), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  // Behavioural stand-in for the external 4-bit ripple adder.
  assign {adder_cout, adder_sum} = {1'b0, adder_x} + {1'b0, adder_y} + {4'b0, adder_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    int sa, sb, sr;
    int unsigned ua, ub;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      sr = sa - sb;
      c  = (ua >= ub);
      r  = W'(ua - ub);
    end else begin
      sr = sa + sb;
      c  = (ua + ub) > 32'hFFFF;
      r  = W'(ua + ub);
    end
    o = (sr > 32767) || (sr < -32768);
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
    if (o) r = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    z = (r == '0);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  // Runs one operation; out_ready is held low for `hold` cycles of DONE while
  // a stray request is offered.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int hold);
    logic [W-1:0] er; logic ec, eo, ez;
    int lat;
    model(a, b, sub, er, ec, eo, ez);
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    chk("first_x",   {28'b0, adder_x},   {28'b0, a[3:0]});
    chk("first_y",   {28'b0, adder_y},   {28'b0, b[3:0] ^ {4{sub}}});
    chk("first_cin", {31'b0, adder_cin}, {31'b0, sub});
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", lat, N + 1);
    chk("result",   {16'b0, out_result},  {16'b0, er});
    chk("carry",    {31'b0, out_carry},    {31'b0, ec});
    chk("overflow", {31'b0, out_overflow}, {31'b0, eo});
    chk("zero",     {31'b0, out_zero},     {31'b0, ez});
    chk("idle_adder", {23'b0, adder_x, adder_y, adder_cin}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
      @(negedge clk);
      chk("bp_ready",  {31'b0, in_ready},  32'd0);
      chk("bp_valid",  {31'b0, out_valid}, 32'd1);
      chk("bp_result", {16'b0, out_result}, {16'b0, er});
      chk("bp_flags",  {29'b0, out_carry, out_overflow, out_zero}, {29'b0, ec, eo, ez});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_ready", {31'b0, in_ready},  32'd1);
    chk("ret_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_outs", {out_valid, out_result, out_carry, out_overflow, out_zero,
                     adder_x, adder_y, adder_cin}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(16'h0005, 16'h0005, 1'b1, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1);
    do_op(16'hABCD, 16'h1111, 1'b0, 3);

    // Reset in the middle of RUN, at nibble step 2.
    wait_ready();
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_x", {28'b0, adder_x}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {out_valid, out_result, out_carry, out_overflow, out_zero,
                         adder_x, adder_y, adder_cin}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_valid", {31'b0, out_valid}, 32'd0);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      if (k % 8 == 0) rb = ra;
      if (k % 8 == 1) ra = 16'h7FFF;
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

- Multi-cycle add/subtract sequencer for WIDTH-bit operands.
- Sits on both sides of the 4-bit ripple adder (`fourbi_adder`): drives its `x`, `y` and `cin` inputs one nibble per cycle, and consumes its `sum` and `cout`.
- Chains carry between nibbles through a register, assembles the full result and status flags, and returns them over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble steps.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  sequencer can accept an operation
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A−B, 0 = A+B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  sum/difference
- out_carry  out  1  final adder carry (for subtract, 1 = no borrow)
- out_overflow  out  1  signed two's-complement overflow
- out_zero  out  1  out_result == 0
- adder_x  out  4  nibble of A to the adder
- adder_y  out  4  nibble of B, inverted when subtracting
- adder_cin  out  1  carry into the adder
- adder_sum  in  4  adder sum
- adder_cout  in  1  adder carry out

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: latch a_reg, b_reg, sub_reg; clear idx; go to RUN.
- **RUN** (idx = 0..N−1):
  - adder_x = a_reg[4·idx+3 : 4·idx].
  - adder_y = b_reg nibble XOR {4{sub_reg}}.
  - adder_cin = sub_reg when idx == 0, else carry_reg.
  - At the clock edge: store adder_sum into res_reg nibble idx, and adder_cout into carry_reg.
  - At idx == N−1: go to DONE; otherwise idx++.
- **DONE**
  - out_valid = 1; all outputs held stable.
  - On out_ready: go to IDLE.
- in_ready = 1 only in IDLE. in_valid outside IDLE is ignored and the operation is not captured.
- Adder drive outputs (adder_x, adder_y, adder_cin) are 0 in IDLE and DONE.
- The adder path is purely combinational. adder_sum/adder_cout are sampled in the same cycle the operands are presented.
- Flags, computed at DONE from registered values:
  - out_carry = carry_reg.
  - out_zero = (out_result == 0).
  - out_overflow = (a_msb == b'_msb) && (res_msb != a_msb), where b' = b_reg XOR {WIDTH{sub_reg}}.
- Arithmetic is modulo 2^WIDTH (unless saturation is compiled in; see Configuration).
- Reset behaviour:
  - Any rst_n assertion forces IDLE immediately and zeroes all registers and outputs.
  - An operation in flight is discarded with no output.
- Reset values: in_ready 1, out_valid 0, out_result 0, out_carry 0, out_overflow 0, out_zero 0, adder_x 0, adder_y 0, adder_cin 0.

## Timing
- Operation accepted in cycle T.
- Nibbles are processed in cycles T+1 … T+N.
- out_valid rises in cycle T+N+1 (T+5 for WIDTH = 16).
- The DONE→IDLE handshake consumes the cycle where out_valid && out_ready; in_ready returns the next cycle.
- Minimum initiation interval: N+2 cycles. Not pipelined.
- Backpressure: DONE holds indefinitely; outputs are bit-stable while out_valid && !out_ready.
- No combinational path from in_valid or out_ready to any output except through state.

## Configuration
- Macro: NIBBLE_SERIAL_ADDSUB_SAT_EN.
- **Defined**:
  - On overflow, out_result is clamped to the signed extreme: 0x7FFF when A's sign bit is 0, 0x8000 when it is 1 (WIDTH-generalised).
  - out_overflow still reports 1.
  - out_zero is computed on the clamped value.
  - out_carry is unchanged.
- **Undefined**: out_result wraps (raw res_reg).

## Structure
- Shared package nibble_serial_addsub_pkg:
  - state enum (IDLE/RUN/DONE)
  - NIBBLE_W = 4
  - function computing step count from WIDTH
- Sub-module nibble_addsub_flags (combinational): takes res_reg, a_msb, b'_msb, carry_reg; produces out_result (saturated or not), overflow, zero, carry.
- The 4-bit adder stays external and is connected at the parent level.

## Test plan
All scenarios use WIDTH = 16, with `fourbi_adder` connected.
1. Add 0x1234 + 0x0FFF → out_result 0x2233, carry 0, overflow 0, zero 0; out_valid exactly 5 cycles after accept.
2. Subtract 0x0005 − 0x0005 → 0x0000, carry 1, zero 1, overflow 0; adder_cin = 1 on the first nibble.
3. Add 0x7FFF + 0x0001 → 0x8000 with overflow 1, carry 0; with NIBBLE_SERIAL_ADDSUB_SAT_EN → 0x7FFF with overflow 1.
4. Subtract 0x0000 − 0x0001 → 0xFFFF, carry 0 (borrow), overflow 0; subtract 0x8000 − 0x0001 → overflow 1 (0x7FFF wrapped, or 0x8000 when saturating).
5. Hold out_ready low for 3 cycles while pulsing in_valid with new operands → result bits stable, in_ready 0, new request not captured; release out_ready → in_ready 1 the next cycle.
6. Assert rst_n low during RUN step idx = 2 → all outputs 0 immediately, no out_valid; after release, add 0x0001 + 0x0001 → 0x0002.
